trivium_stream: RTL and testbench
=================================

Name: trivium_stream

Overview:
- Parametrised, multi-bit-per-cycle Trivium keystream engine with XOR datapath.
- Replaces single-bit, single-cycle-initialisation cipher cores.
- Key/IV load starts a multi-cycle warm-up; the block then encrypts or decrypts a valid/ready word stream, producing W keystream bits per accepted word.
- Sits between the packet framer and the link transmitter; with in_data tied to zero it is a raw keystream source.

Parameters:
- W, 8, keystream bits per cycle. Legal range 1..64; INIT_STEPS must be divisible by W.
- INIT_STEPS, 1152, warm-up cipher steps before the first output (4×288). Smaller values are for debug only.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle pulse; samples key and iv and starts initialisation.
- key  input  80  cipher key, bit 1 = first key bit.
- iv  input  80  initialisation vector, bit 1 = first IV bit.
- busy  output  1  high while in INIT.
- ks_ready  output  1  high while in RUN.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid & in_ready.
- in_data  input  W  plaintext or ciphertext word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_data  output  W  in_data XOR keystream.

Behaviour:
- **State registers:** A[92:0], B[83:0], C[110:0].
- **Load values:** A = {13'b0, key}, B = {4'b0, iv}, C = {3'b111, 108'b0}.
- **One cipher step:**
  - t1 = A[65]^A[92]; t2 = B[68]^B[83]; t3 = C[65]^C[110]; z = t1^t2^t3.
  - a1 = t1^(A[90]&A[91])^B[77]; a2 = t2^(B[81]&B[82])^C[86]; a3 = t3^(C[108]&C[109])^A[68].
  - Shift each register left by 1, then A[0]=a3, B[0]=a1, C[0]=a2.
- **Per-cycle unroll:** one clock advance = W chained steps, computed combinationally. Step k (0 = earliest) supplies keystream bit k; out_data[0] is the earliest bit.
- **FSM states:** IDLE, INIT, RUN.
  - IDLE: in_ready=0. load → INIT.
  - INIT: registers load on the load cycle and cnt clears to 0. Each following cycle advances W steps (keystream discarded) and cnt increments. When cnt reaches INIT_STEPS/W−1 and that advance completes → RUN. busy=1 for exactly INIT_STEPS/W cycles, starting the cycle after load.
  - RUN: in_ready = !out_valid | out_ready.
    - On an input handshake: out_data <= in_data ^ ks[W-1:0], out_valid <= 1, and the cipher advances W steps in the same cycle.
    - No handshake → cipher holds; the keystream is never skipped or reused.
    - out_valid clears when out_ready=1 and no new input handshake occurs.
    - Back-to-back throughput is 1 word/cycle. Latency is 1 cycle from input handshake to out_valid.
- **Output stability:** out_data/out_valid stay stable while out_valid & !out_ready.
- **load in any state (rekey):**
  - Abandons the current stream and reloads registers.
  - out_valid <= 0 in the same edge; any pending output word is dropped.
  - Enters INIT. Any input handshake in that cycle is ignored, since in_ready is forced to 0 while load=1.
- **load while busy:** initialisation restarts from cnt=0.
- **Reset:** state IDLE; A, B, C, cnt = 0; out_valid=0; out_data=0; busy=0; ks_ready=0; in_ready=0. rst overrides load in the same cycle.
- **Warm-up counter:** cnt width = clog2(INIT_STEPS/W)+1. No wrap occurs in RUN; the keystream length is unbounded.

Test Plan:
- **Reset values:** assert rst 3 cycles with load=1 and in_valid=1 → all outputs 0; state stays IDLE after rst drops.
- **Golden match:**
  - Stimulus: W=8, key=80'h0, iv=80'h0; load, stream 32 zero words with out_ready=1.
  - Required: busy high exactly 144 cycles; ks_ready at cycle 145.
  - Required: out_data matches a bit-serial golden model (same step equations, LSB-first packing) for all 256 bits.
- **Width independence:**
  - Stimulus: instances with W=1, 16 and 64; key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100000; 512 keystream bits.
  - Required: identical bit sequences across instances; busy durations 1152, 72 and 18 cycles.
- **Backpressure:**
  - Stimulus: random in_valid/out_ready (50%), 1000 words.
  - Required: no word lost or duplicated, out_data stable while stalled, decrypting with a second instance restores the plaintext.
  - Required: ciphertext identical to the no-stall run.
- **Rekey mid-stream:**
  - Stimulus: load a new key after 10 words while out_valid=1 and out_ready=0.
  - Required: pending word dropped, busy asserts next cycle, and the following stream equals a fresh run with the new key.
- **Edge cases:**
  - load during INIT at cnt=50 → busy lasts 144 cycles from the second load.
  - rst during RUN → IDLE next cycle, and out_valid=0.

Source files
------------

// File: rtl/trivium_stream.sv
// trivium_stream: W-bit-per-cycle Trivium keystream engine with an XOR datapath.
// A load pulse samples key/iv and starts an INIT_STEPS-step warm-up. After that,
// each accepted input word is XORed with the next W keystream bits.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   load, key, iv       one-cycle rekey pulse with the 80-bit key and IV
//   busy                high while warming up (INIT)
//   ks_ready            high while streaming (RUN)
//   in_valid/in_ready   input word handshake, in_data is W bits
//   out_valid/out_ready output word handshake, out_data = in_data ^ keystream
module trivium_stream #(
    parameter int unsigned W          = 8,
    parameter int unsigned INIT_STEPS = 1152
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [79:0]   key,
    input  logic [79:0]   iv,
    output logic          busy,
    output logic          ks_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data
);

    localparam int unsigned NINIT = INIT_STEPS / W;
    localparam int unsigned CW    = $clog2(NINIT) + 1;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t         state, state_nx;
    logic [92:0]    a, a_nx;
    logic [83:0]    b, b_nx;
    logic [110:0]   c, c_nx;
    logic [W-1:0]   ks;
    logic [CW-1:0]  cnt;
    logic           hs;
    logic           last;
    logic           t1, t2, t3, f1, f2, f3;

    // W chained cipher steps; iteration k produces keystream bit k.
    always_comb begin
        a_nx = a;
        b_nx = b;
        c_nx = c;
        ks   = '0;
        t1   = 1'b0;
        t2   = 1'b0;
        t3   = 1'b0;
        f1   = 1'b0;
        f2   = 1'b0;
        f3   = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            t1    = a_nx[65] ^ a_nx[92];
            t2    = b_nx[68] ^ b_nx[83];
            t3    = c_nx[65] ^ c_nx[110];
            ks[k] = t1 ^ t2 ^ t3;
            f1    = t1 ^ (a_nx[90] & a_nx[91]) ^ b_nx[77];
            f2    = t2 ^ (b_nx[81] & b_nx[82]) ^ c_nx[86];
            f3    = t3 ^ (c_nx[108] & c_nx[109]) ^ a_nx[68];
            a_nx  = {a_nx[91:0], f3};
            b_nx  = {b_nx[82:0], f1};
            c_nx  = {c_nx[109:0], f2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state == INIT);
        ks_ready = (state == RUN);
        // load blocks the input side so a rekey cycle never consumes a word
        in_ready = (state == RUN) && !load && (!out_valid || out_ready);
        hs       = in_valid && in_ready;
        last     = (cnt == CW'(NINIT - 1));
        if (load) begin
            state_nx = INIT;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                INIT:    if (last) state_nx = RUN;
                RUN:     state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            a         <= {13'b0, key};
            b         <= {4'b0, iv};
            c         <= {3'b111, 108'b0};
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == INIT) begin
                a   <= a_nx;
                b   <= b_nx;
                c   <= c_nx;
                cnt <= cnt + CW'(1);
            end
            if (hs) begin
                a         <= a_nx;
                b         <= b_nx;
                c         <= c_nx;
                out_data  <= in_data ^ ks;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: directed bench for trivium_stream. Expected keystream comes
// from a bit-serial reference generator built from the cipher step equations.
module tb_trivium_stream;

    logic         clk = 1'b0;
    logic         rst, load;
    logic [79:0]  key, iv;
    logic         in_valid, out_ready;
    logic [7:0]   in_data;
    logic         busy, ks_ready, in_ready, out_valid;
    logic [7:0]   out_data;

    logic         dec_valid, dec_ready;
    logic [7:0]   dec_data;
    logic         dec_busy, dec_ks_ready, dec_in_ready, dec_out_valid;
    logic [7:0]   dec_out_data;

    logic         b1, r1, k1, v1;
    logic [0:0]   d1;
    logic         b16, r16, k16, v16;
    logic [15:0]  d16;
    logic         b64, r64, k64, v64;
    logic [63:0]  d64;

    int checks = 0;
    int errors = 0;

    bit          gold [0:8191];
    logic [7:0]  pt   [0:999];
    logic [7:0]  ct   [0:999];

    always #5 clk = ~clk;

    trivium_stream #(.W(8), .INIT_STEPS(1152)) dut (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(busy), .ks_ready(ks_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    trivium_stream #(.W(8), .INIT_STEPS(1152)) udec (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(dec_busy), .ks_ready(dec_ks_ready),
        .in_valid(dec_valid), .in_ready(dec_in_ready), .in_data(dec_data),
        .out_valid(dec_out_valid), .out_ready(dec_ready), .out_data(dec_out_data)
    );

    trivium_stream #(.W(1), .INIT_STEPS(1152)) u1 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(b1), .ks_ready(k1),
        .in_valid(1'b1), .in_ready(r1), .in_data(1'b0),
        .out_valid(v1), .out_ready(1'b1), .out_data(d1)
    );

    trivium_stream #(.W(16), .INIT_STEPS(1152)) u16 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(b16), .ks_ready(k16),
        .in_valid(1'b1), .in_ready(r16), .in_data(16'h0),
        .out_valid(v16), .out_ready(1'b1), .out_data(d16)
    );

    trivium_stream #(.W(64), .INIT_STEPS(1152)) u64 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(b64), .ks_ready(k64),
        .in_valid(1'b1), .in_ready(r64), .in_data(64'h0),
        .out_valid(v64), .out_ready(1'b1), .out_data(d64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference keystream: 1152 discarded steps, then n bits into gold[].
    task automatic model(input logic [79:0] k, input logic [79:0] v, input int n);
        logic [92:0]  ra;
        logic [83:0]  rb;
        logic [110:0] rc;
        logic         s1, s2, s3, n1, n2, n3;
        ra = {13'b0, k};
        rb = {4'b0, v};
        rc = {3'b111, 108'b0};
        for (int i = 0; i < 1152 + n; i++) begin
            s1 = ra[65] ^ ra[92];
            s2 = rb[68] ^ rb[83];
            s3 = rc[65] ^ rc[110];
            if (i >= 1152) gold[i - 1152] = s1 ^ s2 ^ s3;
            n1 = s1 ^ (ra[90] & ra[91]) ^ rb[77];
            n2 = s2 ^ (rb[81] & rb[82]) ^ rc[86];
            n3 = s3 ^ (rc[108] & rc[109]) ^ ra[68];
            ra = {ra[91:0], n3};
            rb = {rb[82:0], n1};
            rc = {rc[109:0], n2};
        end
    endtask

    function automatic logic [7:0] ksw(input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = gold[8*k + j];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic load_pulse(input logic [79:0] k, input logic [79:0] v);
        key  = k;
        iv   = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Streams n words through dut; rnd enables random valid/ready.
    task automatic run_stream(input int n, input bit rnd, input bit zpt);
        int         ii = 0;
        int         oi = 0;
        int         cyc = 0;
        bit         held_v = 1'b0;
        logic [7:0] held = '0;
        for (int k = 0; k < n; k++) pt[k] = zpt ? 8'h00 : 8'($urandom);
        while (oi < n && cyc < 20*n + 100) begin
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
            in_valid  = (ii < n) && (!rnd || $urandom_range(1, 0) == 1);
            in_data   = (ii < n) ? pt[ii] : 8'h00;
            out_ready = !rnd || $urandom_range(1, 0) == 1;
            #1;
            held_v = out_valid && !out_ready;
            held   = out_data;
            if (out_valid && out_ready) begin
                chk("word", out_data, pt[oi] ^ ksw(oi));
                ct[oi] = out_data;
                oi++;
            end
            if (in_valid && in_ready) ii++;
            @(negedge clk);
            cyc++;
        end
        chk("stream_count", oi, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("no_extra_word", out_valid, 0);
    endtask

    initial begin
        int            n, nb1, nb8, nb16, nb64, n1, n8, n16, n64, di, dq;
        logic [511:0]  s1, s8, s16, s64, gv;

        rst = 1'b1; load = 1'b1; key = '1; iv = '1;
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        dec_valid = 1'b0; dec_data = '0; dec_ready = 1'b1;

        // reset dominates load
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_ks_ready", ks_ready, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
        end
        rst = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ks_ready", ks_ready, 0);
        chk("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        // golden run, all-zero key and IV
        model(80'h0, 80'h0, 256);
        load_pulse(80'h0, 80'h0);
        count_busy(n);
        chk("golden_busy_len", n, 144);
        chk("golden_ks_ready", ks_ready, 1);
        run_stream(32, 1'b0, 1'b1);

        // backpressure plus decryption by a second instance
        model(80'h3C5A_0F1E_2D4B_6978_8796, 80'h1122_3344_5566_7788_99AA, 8000);
        load_pulse(80'h3C5A_0F1E_2D4B_6978_8796, 80'h1122_3344_5566_7788_99AA);
        count_busy(n);
        chk("bp_busy_len", n, 144);
        run_stream(1000, 1'b1, 1'b0);
        chk("dec_ks_ready", dec_ks_ready, 1);
        chk("dec_busy", dec_busy, 0);
        di = 0; dq = 0;
        for (int cyc = 0; cyc < 3000 && dq < 1000; cyc++) begin
            dec_valid = (di < 1000);
            dec_data  = (di < 1000) ? ct[di] : 8'h00;
            #1;
            if (dec_out_valid) begin
                chk("decrypt", dec_out_data, pt[dq]);
                dq++;
            end
            if (dec_valid && dec_in_ready) di++;
            @(negedge clk);
        end
        chk("dec_count", dq, 1000);
        dec_valid = 1'b0;

        // width independence across W = 1, 8, 16, 64
        model(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 512);
        for (int i = 0; i < 512; i++) gv[i] = gold[i];
        s1 = '0; s8 = '0; s16 = '0; s64 = '0;
        nb1 = 0; nb8 = 0; nb16 = 0; nb64 = 0;
        n1 = 0; n8 = 0; n16 = 0; n64 = 0;
        in_data = 8'h00; out_ready = 1'b1;
        load_pulse(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 2500 && (n1 < 512 || n8 < 512 || n16 < 512 || n64 < 512); cyc++) begin
            if (b1)   nb1++;
            if (busy) nb8++;
            if (b16)  nb16++;
            if (b64)  nb64++;
            if (v1 && n1 < 512) begin s1[n1] = d1[0]; n1++; end
            if (out_valid && n8 < 512) begin
                for (int j = 0; j < 8; j++) s8[n8 + j] = out_data[j];
                n8 += 8;
            end
            if (v16 && n16 < 512) begin
                for (int j = 0; j < 16; j++) s16[n16 + j] = d16[j];
                n16 += 16;
            end
            if (v64 && n64 < 512) begin
                for (int j = 0; j < 64; j++) s64[n64 + j] = d64[j];
                n64 += 64;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("w1_busy_len", nb1, 1152);
        chk("w8_busy_len", nb8, 144);
        chk("w16_busy_len", nb16, 72);
        chk("w64_busy_len", nb64, 18);
        chk("w1_ks_ready", k1, 1);
        chk("w16_ks_ready", k16, 1);
        chk("w64_ks_ready", k64, 1);
        chk("w1_in_ready", r1, 1);
        chk("w16_in_ready", r16, 1);
        chk("w64_in_ready", r64, 1);
        for (int q = 0; q < 8; q++) begin
            chk("w1_bits", s1[64*q +: 64], gv[64*q +: 64]);
            chk("w8_bits", s8[64*q +: 64], gv[64*q +: 64]);
            chk("w16_bits", s16[64*q +: 64], gv[64*q +: 64]);
            chk("w64_bits", s64[64*q +: 64], gv[64*q +: 64]);
        end

        // rekey while an output word is stalled
        model(80'hA1B2_C3D4_E5F6_0718_293A, 80'h0F0F_F0F0_5555_AAAA_1234, 80);
        load_pulse(80'hA1B2_C3D4_E5F6_0718_293A, 80'h0F0F_F0F0_5555_AAAA_1234);
        count_busy(n);
        chk("rk_first_busy_len", n, 144);
        run_stream(10, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        #1;
        chk("rk_pre_in_ready", in_ready, 1);
        @(negedge clk);
        chk("rk_pending", out_valid, 1);
        key = 80'h9988_7766_5544_3322_1100; iv = 80'hCAFE_BABE_DEAD_BEEF_0042;
        load = 1'b1;
        #1;
        chk("rk_load_in_ready", in_ready, 0);
        @(negedge clk);
        load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rk_dropped", out_valid, 0);
        chk("rk_busy_next", busy, 1);
        count_busy(n);
        chk("rk_busy_len", n, 144);
        model(80'h9988_7766_5544_3322_1100, 80'hCAFE_BABE_DEAD_BEEF_0042, 160);
        run_stream(20, 1'b0, 1'b0);

        // load again in the middle of warm-up (cnt = 50)
        load_pulse(80'hA1B2_C3D4_E5F6_0718_293A, 80'h0F0F_F0F0_5555_AAAA_1234);
        repeat (50) @(negedge clk);
        chk("mid_busy", busy, 1);
        load_pulse(80'h5555_0000_FFFF_1234_ABCD, 80'h0F0F_F0F0_5555_AAAA_1234);
        count_busy(n);
        chk("mid_busy_len", n, 144);
        model(80'h5555_0000_FFFF_1234_ABCD, 80'h0F0F_F0F0_5555_AAAA_1234, 64);
        run_stream(8, 1'b0, 1'b0);

        // reset while streaming
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("run_rst_busy", busy, 0);
        chk("run_rst_ks_ready", ks_ready, 0);
        chk("run_rst_out_valid", out_valid, 0);
        chk("run_rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ks_ready", ks_ready, 0);
        chk("post_rst_in_ready", in_ready, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
